// File: rtl/vga_pkg.sv
// Shared types and 800x600@60 timing constants for the VGA line-fetch path.
package vga_pkg;

  localparam int RGB_W    = 30;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int H_TOTAL  = 1056;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vga_line_buf.sv
// Two-bank line buffer: one write port (bank, index, data), one registered read port.
module vga_line_buf
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int IDX_W    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic             i_wr_bank,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [RGB_W-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic             i_rd_bank,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [RGB_W-1:0] o_rd_data
);

  localparam int DEPTH   = 2 * H_ACTIVE;
  localparam int DEPTH_W = $clog2(DEPTH);

  logic [RGB_W-1:0]   r_mem [0:DEPTH-1];
  logic [DEPTH_W-1:0] w_wr_addr;
  logic [DEPTH_W-1:0] w_rd_addr;

  // Bank 1 occupies the upper H_ACTIVE words.
  assign w_wr_addr = i_wr_bank ? DEPTH_W'(H_ACTIVE) + DEPTH_W'(i_wr_idx) : DEPTH_W'(i_wr_idx);
  assign w_rd_addr = i_rd_bank ? DEPTH_W'(H_ACTIVE) + DEPTH_W'(i_rd_idx) : DEPTH_W'(i_rd_idx);

  // Read-before-write: a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[w_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[w_rd_addr];
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Prefetches the next active line from pixel memory into a two-bank buffer and plays
// the current line out on de. Optional macro VGA_UNDERRUN_CNT_EN adds underrun_cnt.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int ADDR_W    = 19,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              line_end,
  input  logic              de,
  output logic [RGB_W-1:0]  rgb30,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [RGB_W-1:0]  mem_rdata,
  output logic              busy,
  output logic              underrun,
  output logic [1:0]        dbg_state
`ifdef VGA_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int WORD_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LINE_W = $clog2(V_ACTIVE + 1);

  localparam logic [WORD_W-1:0] W_LAST    = WORD_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] L_V       = LINE_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] A_BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] A_H       = ADDR_W'(H_ACTIVE);
  localparam bit                TWO_LINES = (V_ACTIVE > 1);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_line_base;
  logic [WORD_W-1:0] r_word;
  logic [LINE_W-1:0] r_fetch_line;
  logic              r_wr_bank;
  logic              r_restart;
  logic              r_underrun;
  logic              r_rd_bank;
  logic [WORD_W-1:0] r_rd_ptr;
  logic              r_de_d;
  logic [RGB_W-1:0]  w_rd_data;

  logic              w_ack_ok;
  logic              w_event;
  logic              w_redirect;
  logic              w_last_word;
  logic              w_underrun_evt;
  logic [LINE_W-1:0] w_tgt_line;
  logic [ADDR_W-1:0] w_tgt_base;
  logic [LINE_W-1:0] w_new_line;
  logic [ADDR_W-1:0] w_new_base;

  // Memory handshake: mem_req is high for the whole FETCH state and mem_addr only
  // moves on the cycle after a mem_ack; an ack while mem_req is low is ignored.
  assign mem_req   = (r_state == S_FETCH);
  assign busy      = (r_state == S_FETCH);
  assign mem_addr  = r_addr;
  assign underrun  = r_underrun;
  assign dbg_state = r_state;
  assign rgb30     = r_de_d ? w_rd_data : '0;

  assign w_ack_ok       = mem_ack && (r_state == S_FETCH);
  assign w_event        = frame_start || line_end;
  assign w_redirect     = w_event || r_restart;
  assign w_last_word    = (r_word == W_LAST);
  assign w_underrun_evt = (r_state == S_FETCH) && line_end && !frame_start;

  // Line target saturates at V_ACTIVE, which stands for "nothing left this frame".
  assign w_tgt_line = frame_start ? '0
                    : (r_fetch_line == L_V) ? r_fetch_line : r_fetch_line + LINE_W'(1);
  assign w_tgt_base = frame_start ? A_BASE : r_line_base + A_H;
  assign w_new_line = w_event ? w_tgt_line : r_fetch_line;
  assign w_new_base = w_event ? w_tgt_base : r_line_base;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (frame_start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_ack_ok) begin
          if (w_redirect)
            w_state_nxt = (w_new_line < L_V) ? S_FETCH : S_HOLD;
          else if (w_last_word)
            w_state_nxt = (r_fetch_line == '0 && TWO_LINES) ? S_FETCH : S_HOLD;
        end
      end
      S_HOLD: begin
        if (frame_start || (line_end && w_tgt_line < L_V)) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch datapath. r_fetch_line/r_line_base track the line being (or last) fetched;
  // on an underrun they jump ahead at once while r_addr holds the outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= A_BASE;
      r_line_base  <= A_BASE;
      r_word       <= '0;
      r_fetch_line <= '0;
      r_wr_bank    <= 1'b0;
      r_restart    <= 1'b0;
    end else if (r_state == S_FETCH) begin
      if (w_ack_ok) begin
        if (w_redirect) begin
          r_fetch_line <= w_new_line;
          r_line_base  <= w_new_base;
          r_addr       <= w_new_base;
          r_word       <= '0;
          r_wr_bank    <= w_new_line[0];
          r_restart    <= 1'b0;
        end else if (w_last_word) begin
          if (r_fetch_line == '0 && TWO_LINES) begin
            r_fetch_line <= LINE_W'(1);
            r_line_base  <= r_line_base + A_H;
            r_addr       <= r_addr + ADDR_W'(1);
            r_word       <= '0;
            r_wr_bank    <= 1'b1;
          end
        end else begin
          r_word <= r_word + WORD_W'(1);
          r_addr <= r_addr + ADDR_W'(1);
        end
      end else if (w_event) begin
        r_fetch_line <= w_tgt_line;
        r_line_base  <= w_tgt_base;
        r_restart    <= 1'b1;
      end
    end else if (frame_start || (r_state == S_HOLD && line_end)) begin
      r_fetch_line <= w_tgt_line;
      r_line_base  <= w_tgt_base;
      r_addr       <= w_tgt_base;
      r_word       <= '0;
      r_wr_bank    <= w_tgt_line[0];
      r_restart    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                 r_underrun <= 1'b0;
    else if (w_underrun_evt) r_underrun <= 1'b1;
  end

`ifdef VGA_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_underrun_cnt <= '0;
    else if (w_underrun_evt && r_underrun_cnt != 16'hFFFF)
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  // Playout side: frame_start takes priority over a coincident line_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bank <= 1'b0;
      r_rd_ptr  <= '0;
      r_de_d    <= 1'b0;
    end else begin
      r_de_d <= de;
      if (frame_start) begin
        r_rd_bank <= 1'b0;
        r_rd_ptr  <= '0;
      end else if (line_end) begin
        r_rd_bank <= ~r_rd_bank;
        r_rd_ptr  <= '0;
      end else if (de && r_rd_ptr != W_LAST) begin
        r_rd_ptr <= r_rd_ptr + WORD_W'(1);
      end
    end
  end

  vga_line_buf #(
    .H_ACTIVE (H_ACTIVE),
    .IDX_W    (WORD_W)
  ) u_line_buf (
    .clk       (clk),
    .i_wr_en   (w_ack_ok),
    .i_wr_bank (r_wr_bank),
    .i_wr_idx  (r_word),
    .i_wr_data (mem_rdata),
    .i_rd_en   (de),
    .i_rd_bank (r_rd_bank),
    .i_rd_idx  (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with a 4x3 frame at base address 16; memory returns data = address.
module tb_vga_line_fetch;

  localparam int H_ACTIVE  = 4;
  localparam int V_ACTIVE  = 3;
  localparam int ADDR_W    = 19;
  localparam int BASE_ADDR = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic              line_end = 1'b0;
  logic              de = 1'b0;
  logic [29:0]       rgb30;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [29:0]       mem_rdata = '0;
  logic              busy;
  logic              underrun;
  logic [1:0]        dbg_state;
`ifdef VGA_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] acked_q[$];

  bit                ack_en = 1'b0;
  int                ack_delay = 0;
  bit                force_ack = 1'b0;
  int                wait_cnt = 0;
  int                stall_err = 0;
  bit                prev_pending = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  vga_line_fetch #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .line_end     (line_end),
    .de           (de),
    .rgb30        (rgb30),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .underrun     (underrun),
    .dbg_state    (dbg_state)
`ifdef VGA_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  // Clock and time-limit guard
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "time limit reached");
  end

  // Memory model: acks after ack_delay stall cycles, logs every accepted address,
  // and flags any address change while a request is still waiting.
  always @(negedge clk) begin
    if (prev_pending && mem_req && mem_addr !== prev_addr) stall_err++;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 30'd999;
    end else if (ack_en && mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = 30'(mem_addr);
        acked_q.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    prev_pending = mem_req && !mem_ack;
    prev_addr    = mem_addr;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_range(input int first, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(ADDR_W'(first + i));
  endtask

  task automatic check_acks(input string tag);
    check({tag, "_count"}, acked_q.size(), exp_q.size());
    while (exp_q.size() > 0 && acked_q.size() > 0)
      check({tag, "_addr"}, 32'(acked_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    acked_q.delete();
  endtask

  task automatic wait_hold(input string tag, input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_in_budget"}, 32'(k < budget), 32'd1);
  endtask

  task automatic play_line(input string tag, input int first);
    de = 1'b1;
    for (int i = 0; i < H_ACTIVE; i++) begin
      tick();
      if (i == H_ACTIVE - 1) de = 1'b0;
      check(tag, rgb30, 32'(first + i));
    end
  endtask

  task automatic end_line(input bit do_le);
    line_end = do_le;
    tick();
    line_end = 1'b0;
    check("rgb_after_de", rgb30, 32'd0);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Directed sequence
  initial begin
    int k;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_mem_req", mem_req, 0);
    check("reset_busy", busy, 0);
    check("reset_underrun", underrun, 0);
    check("reset_rgb30", rgb30, 0);
    check("reset_mem_addr", mem_addr, BASE_ADDR);
    check("reset_state", dbg_state, vga_pkg::S_IDLE);

    // Frame A: ack every cycle, lines 0 and 1 fetched back-to-back
    ack_en    = 1'b1;
    ack_delay = 0;
    push_range(16, 8);
    pulse_frame_start();
    check("fs_busy", busy, 1);
    check("fs_first_addr", mem_addr, 16);
    wait_hold("fetch01", 30);
    check("fetch01_state", dbg_state, vga_pkg::S_HOLD);
    check("fetch01_req_low", mem_req, 0);
    check_acks("fetch01");

    // Stray ack while idle must not write the buffer or restart a fetch
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("stray_ack_state", dbg_state, vga_pkg::S_HOLD);
    check("stray_ack_req", mem_req, 0);

    tick();
    play_line("line0_rgb", 16);
    ack_delay = 3;
    push_range(24, 4);
    end_line(1'b1);
    check("le0_busy", busy, 1);
    check("le0_addr", mem_addr, 24);

    tick();
    play_line("line1_rgb", 20);
    wait_hold("fetch2_stalled", 60);
    check_acks("fetch2_stalled");
    check("stall_addr_stable", stall_err, 0);
    end_line(1'b1);
    check("le1_no_fetch", busy, 0);

    tick();
    play_line("line2_rgb", 24);
    end_line(1'b1);
    repeat (5) tick();
    check("after_last_req", mem_req, 0);
    check_acks("after_last");

    // Frame B: frame_start and line_end together during a stalled fetch
    pulse_frame_start();
    tick();
    frame_start = 1'b1;
    line_end    = 1'b1;
    tick();
    frame_start = 1'b0;
    line_end    = 1'b0;
    check("fs_le_underrun", underrun, 0);
    check("fs_le_busy", busy, 1);
    check("fs_le_addr_held", mem_addr, 16);
    push_range(16, 1);
    push_range(16, 8);
    wait_hold("fs_le_refetch", 80);
    check_acks("fs_le_refetch");
    check("fs_le_addr_stable", stall_err, 0);
    tick();
    play_line("fs_wins_rgb", 16);
    end_line(1'b0);

    // Frame C: line_end mid-fetch of line 1 is an underrun
    pulse_frame_start();
    k = 0;
    while (acked_q.size() < 5 && k < 100) begin
      tick();
      k++;
    end
    check("reach_line1_word1", 32'(k < 100), 1);
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    check("underrun_set", underrun, 1);
    check("underrun_busy", busy, 1);
    check("underrun_addr_held", mem_addr, 21);
`ifdef VGA_UNDERRUN_CNT_EN
    check("underrun_cnt_one", underrun_cnt, 1);
`endif
    push_range(16, 6);
    push_range(24, 4);
    wait_hold("underrun_restart", 100);
    check_acks("underrun_restart");
    check("underrun_addr_stable", stall_err, 0);
    check("underrun_sticky", underrun, 1);

    // Reset while a request is outstanding
    pulse_frame_start();
    check("pre_reset_req", mem_req, 1);
    rst = 1'b1;
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_rgb30", rgb30, 0);
    check("rst_state", dbg_state, vga_pkg::S_IDLE);
    check("rst_mem_addr", mem_addr, BASE_ADDR);
`ifdef VGA_UNDERRUN_CNT_EN
    check("rst_underrun_cnt", underrun_cnt, 0);
`endif
    rst    = 1'b0;
    ack_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
